// File: rtl/chrono_hex.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : chrono_hex
// Brief    : Debounced start/stop/clear stopwatch (mm:ss.cc) on six 7-seg digits
// Revision : 1.0 - initial release
// ============================================================================
module chrono_hex #(
    parameter int CLK_FREQ_HZ     = 50_000_000,
    parameter int TICK_HZ         = 100,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] key,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3,
    output logic [6:0] hex4,
    output logic [6:0] hex5,
    output logic       running,
    output logic       tick
);

    localparam int c_div = CLK_FREQ_HZ / TICK_HZ;
    localparam int c_pw  = (c_div > 1) ? $clog2(c_div) : 1;
    localparam int c_dw  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_pw-1:0] c_presc_last = c_pw'(c_div - 1);
    localparam logic [c_dw-1:0] c_db_last    = c_dw'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    logic [1:0]      r_sync1;
    logic [1:0]      r_sync2;
    logic [1:0]      r_acc;
    logic [1:0]      r_press;
    logic [c_dw-1:0] r_db_cnt [2];

    state_t          r_state;
    state_t          w_state_next;
    logic            w_clear;
    logic            r_running;
    logic            w_tick;
    logic [c_pw-1:0] r_presc;
    logic [3:0]      r_cc0, r_cc1, r_ss0, r_ss1, r_mm0, r_mm1;

    // Accepted level only flips after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 2'b11;
            r_sync2 <= 2'b11;
            r_acc   <= 2'b11;
            r_press <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= key;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 2; i++) begin
                r_press[i] <= 1'b0;
                if (r_sync2[i] == r_acc[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == c_db_last) begin
                    r_db_cnt[i] <= '0;
                    r_acc[i]    <= r_sync2[i];
                    r_press[i]  <= ~r_sync2[i];
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_press[0]) w_state_next = S_RUN;
            end
            S_RUN: begin
                if (r_press[0]) w_state_next = S_PAUSE;
            end
            S_PAUSE: begin
                if (r_press[1]) begin
                    w_state_next = S_IDLE;
                    w_clear      = 1'b1;
                end else if (r_press[0]) begin
                    w_state_next = S_RUN;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_running <= (w_state_next == S_RUN);
        end
    end

    assign w_tick  = (r_state == S_RUN) && (r_presc == c_presc_last);
    assign tick    = w_tick;
    assign running = r_running;

    // Prescaler holds in PAUSE; BCD digits ripple-carry only on the tick cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
            r_cc0 <= 4'd0; r_cc1 <= 4'd0;
            r_ss0 <= 4'd0; r_ss1 <= 4'd0;
            r_mm0 <= 4'd0; r_mm1 <= 4'd0;
        end else if (w_clear) begin
            r_presc <= '0;
            r_cc0 <= 4'd0; r_cc1 <= 4'd0;
            r_ss0 <= 4'd0; r_ss1 <= 4'd0;
            r_mm0 <= 4'd0; r_mm1 <= 4'd0;
        end else if (r_state == S_RUN) begin
            if (w_tick) begin
                r_presc <= '0;
                if (r_cc0 != 4'd9) begin
                    r_cc0 <= r_cc0 + 4'd1;
                end else begin
                    r_cc0 <= 4'd0;
                    if (r_cc1 != 4'd9) begin
                        r_cc1 <= r_cc1 + 4'd1;
                    end else begin
                        r_cc1 <= 4'd0;
                        if (r_ss0 != 4'd9) begin
                            r_ss0 <= r_ss0 + 4'd1;
                        end else begin
                            r_ss0 <= 4'd0;
                            if (r_ss1 != 4'd5) begin
                                r_ss1 <= r_ss1 + 4'd1;
                            end else begin
                                r_ss1 <= 4'd0;
                                if (r_mm0 != 4'd9) begin
                                    r_mm0 <= r_mm0 + 4'd1;
                                end else begin
                                    r_mm0 <= 4'd0;
                                    r_mm1 <= (r_mm1 != 4'd5) ? r_mm1 + 4'd1 : 4'd0;
                                end
                            end
                        end
                    end
                end
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7f;
        endcase
    endfunction

    assign hex0 = seg7(r_cc0);
    assign hex1 = seg7(r_cc1);
    assign hex2 = seg7(r_ss0);
    assign hex3 = seg7(r_ss1);
    assign hex4 = seg7(r_mm0);
    assign hex5 = seg7(r_mm1);

endmodule
`default_nettype wire

// File: tb/tb_chrono_hex.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_chrono_hex
// Brief    : Directed/randomized bench for chrono_hex against a time-based model
// Revision : 1.0 - initial release
// ============================================================================
module tb_chrono_hex;

    localparam int CLK_FREQ_HZ = 100;
    localparam int TICK_HZ     = 10;
    localparam int DB          = 4;
    localparam int DIV         = CLK_FREQ_HZ / TICK_HZ;
    localparam int CS_WRAP     = 60 * 60 * 100;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] key;
    logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
    logic       running;
    logic       tick;

    always #5 clk = ~clk;

    chrono_hex #(
        .CLK_FREQ_HZ    (CLK_FREQ_HZ),
        .TICK_HZ        (TICK_HZ),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .key    (key),
        .hex0   (hex0),
        .hex1   (hex1),
        .hex2   (hex2),
        .hex3   (hex3),
        .hex4   (hex4),
        .hex5   (hex5),
        .running(running),
        .tick   (tick)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: elapsed centiseconds plus cycles into the current one
    int            m_state;
    int            m_phase;
    int            m_cs;
    logic          m_acc   [2];
    logic          m_press [2];
    logic [DB+1:0] m_hist  [2];

    int lat;
    int prev_cs;
    int hold;

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: seg = 7'h40;  1: seg = 7'h79;  2: seg = 7'h24;  3: seg = 7'h30;
            4: seg = 7'h19;  5: seg = 7'h12;  6: seg = 7'h02;  7: seg = 7'h78;
            8: seg = 7'h00;  9: seg = 7'h10;
            default: seg = 7'h7f;
        endcase
    endfunction

    function automatic logic [41:0] exp_hex(input int cs);
        int mm, ss, cc;
        mm = cs / 6000;
        ss = (cs / 100) % 60;
        cc = cs % 100;
        exp_hex = {seg(mm / 10), seg(mm % 10), seg(ss / 10), seg(ss % 10),
                   seg(cc / 10), seg(cc % 10)};
    endfunction

    task automatic chk(input string tag, input logic [41:0] obs, input logic [41:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_state = 0;
        m_phase = 0;
        m_cs    = 0;
        for (int i = 0; i < 2; i++) begin
            m_acc[i]   = 1'b1;
            m_press[i] = 1'b0;
            m_hist[i]  = '1;
        end
    endtask

    task automatic model_edge(input logic [1:0] k);
        if (m_state == 1) begin
            if (m_phase == DIV - 1) begin
                m_phase = 0;
                m_cs    = (m_cs + 1) % CS_WRAP;
            end else begin
                m_phase++;
            end
        end
        case (m_state)
            0: if (m_press[0]) m_state = 1;
            1: if (m_press[0]) m_state = 2;
            2: if (m_press[1]) begin
                   m_state = 0;
                   m_cs    = 0;
                   m_phase = 0;
               end else if (m_press[0]) begin
                   m_state = 1;
               end
            default: m_state = 0;
        endcase
        // A level is accepted once the synchronised pin (2 samples late) differed DB times in a row
        for (int i = 0; i < 2; i++) begin
            m_hist[i]  = {m_hist[i][DB:0], k[i]};
            m_press[i] = 1'b0;
            if (m_hist[i][DB+1:2] == {DB{~m_acc[i]}}) begin
                m_acc[i]   = ~m_acc[i];
                m_press[i] = ~m_acc[i];
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) model_edge(key);
        #1;
        chk("hex", {hex5, hex4, hex3, hex2, hex1, hex0}, exp_hex(m_cs));
        chk("running", 42'(running), 42'(m_state == 1));
        chk("tick", 42'(tick), 42'((m_state == 1) && (m_phase == DIV - 1)));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic press(input logic [1:0] mask, input int hold_cycles);
        key = key & ~mask;
        steps(hold_cycles);
        key = key | mask;
        steps(DB + 3);
    endtask

    // Called just after an edge: reset lands mid-cycle and is checked before the next edge
    task automatic do_reset(input int cycles);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_hex", {hex5, hex4, hex3, hex2, hex1, hex0}, {6{7'h40}});
        chk("rst_running", 42'(running), 42'd0);
        chk("rst_tick", 42'(tick), 42'd0);
        steps(cycles);
        rst = 1'b0;
    endtask

    task automatic preload(input bit top);
        if (top) begin
            force dut.r_mm1 = 4'd5;
            force dut.r_mm0 = 4'd9;
        end else begin
            force dut.r_mm1 = 4'd0;
            force dut.r_mm0 = 4'd0;
        end
        force dut.r_ss1 = 4'd5;
        force dut.r_ss0 = 4'd9;
        force dut.r_cc1 = 4'd9;
        force dut.r_cc0 = 4'd9;
        #1;
        release dut.r_mm1;
        release dut.r_mm0;
        release dut.r_ss1;
        release dut.r_ss0;
        release dut.r_cc1;
        release dut.r_cc0;
        m_cs = top ? CS_WRAP - 1 : 5999;
    endtask

    task automatic wait_tick();
        prev_cs = m_cs;
        for (int i = 0; i < 2 * DIV && m_cs == prev_cs; i++) step();
        chk("tick_seen", 42'(m_cs != prev_cs), 42'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        key = 2'b11;
        model_reset();
        steps(3);
        chk("init_hex", {hex5, hex4, hex3, hex2, hex1, hex0}, {6{7'h40}});
        chk("init_running", 42'(running), 42'd0);
        rst = 1'b0;
        steps(5);

        // Short glitches on start/stop, then a stable press
        for (int g = 0; g < int'($urandom_range(2, 4)); g++) begin
            key[0] = 1'b0;
            steps(2);
            key[0] = 1'b1;
            steps($urandom_range(1, 3));
        end
        chk("glitch_idle", 42'(running), 42'd0);
        key[0] = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (running && lat == 0) lat = i;
        end
        chk("press_latency", 42'(lat), 42'(2 + DB + 1));
        key[0] = 1'b1;
        for (int i = 0; i < 100 && m_cs < 3; i++) step();
        chk("three_ticks_hex0", 42'(hex0), 42'h30);
        chk("three_ticks_hex1", 42'(hex1), 42'h40);
        steps($urandom_range(5, 40));

        do_reset(3);
        steps(8);
        chk("post_rst_running", 42'(running), 42'd0);

        press(2'b01, $urandom_range(DB, DB + 6));
        steps($urandom_range(3, 25));
        preload(1'b0);
        wait_tick();
        chk("carry_minute", {hex5, hex4, hex3, hex2, hex1, hex0},
            {7'h40, 7'h79, 7'h40, 7'h40, 7'h40, 7'h40});

        steps($urandom_range(3, 25));
        preload(1'b1);
        wait_tick();
        chk("wrap_hex", {hex5, hex4, hex3, hex2, hex1, hex0}, {6{7'h40}});
        chk("wrap_running", 42'(running), 42'd1);
        steps($urandom_range(10, 30));

        // Clear is ignored in RUN; pause holds, resume continues mid-centisecond
        press(2'b10, $urandom_range(DB, DB + 6));
        chk("clear_ignored", 42'(running), 42'd1);
        steps($urandom_range(1, 9));
        press(2'b01, $urandom_range(DB, DB + 6));
        chk("paused", 42'(m_state), 42'd2);
        steps(50);
        press(2'b01, $urandom_range(DB, DB + 6));
        steps($urandom_range(20, 60));

        press(2'b01, $urandom_range(DB, DB + 6));
        steps($urandom_range(2, 12));
        hold = $urandom_range(DB, DB + 6);
        press(2'b11, hold);
        chk("both_idle_running", 42'(running), 42'd0);
        chk("both_idle_hex", {hex5, hex4, hex3, hex2, hex1, hex0}, {6{7'h40}});
        chk("both_idle_presc", 42'(dut.r_presc), 42'd0);

        press(2'b10, $urandom_range(DB, DB + 6));
        chk("idle_clear", 42'(running), 42'd0);
        press(2'b01, $urandom_range(DB, DB + 6));
        steps($urandom_range(30, 80));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
